// File: rtl/mem_bus_pkg.sv
// Shared encodings for the CPU-side peripheral bus initiator: access sizes,
// FSM states, chip-enable indices and the alignment rule.
package mem_bus_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam int unsigned CE_RAM  = 0;
    localparam int unsigned CE_GPIO = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Halfwords need even addresses, words need 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extract / sign-zero extension for loads.
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wdata,
    output logic [3:0]  we_c,
    output logic [31:0] wdata_c,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_off,
    input  logic        rd_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_c
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Replicate store data across lanes; enables select which lanes commit.
    always_comb begin
        we_c    = 4'b0000;
        wdata_c = 32'h0;
        case (wr_size)
            SZ_B: begin
                we_c    = 4'b0001 << wr_off;
                wdata_c = {4{wdata[7:0]}};
            end
            SZ_H: begin
                we_c    = wr_off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            SZ_W: begin
                we_c    = 4'b1111;
                wdata_c = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_byte = 8'(rdata >> {rd_off, 3'b000});
        rd_half = rd_off[1] ? rdata[31:16] : rdata[15:0];
        rdata_c = 32'h0;
        case (rd_size)
            SZ_B:    rdata_c = rd_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    rdata_c = rd_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            SZ_W:    rdata_c = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// Peripheral bus initiator: one MEM-stage load/store becomes one bus transaction.
// Optional macro MEM_BUS_ERR_CNT_EN adds a saturating error counter output err_count.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned CE_SEL_W   = 2,
    parameter int unsigned BUS_ADDR_W = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic [(1<<CE_SEL_W)-1:0]   bus_ce,
    output logic [3:0]                 bus_we,
    output logic                       bus_re,
    output logic [BUS_ADDR_W-1:0]      bus_addr,
    output logic [31:0]                bus_wdata,
    input  logic [31:0]                bus_rdata
`ifdef MEM_BUS_ERR_CNT_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam int unsigned CE_W = 1 << CE_SEL_W;

    state_t            state;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              unsigned_q;
    logic [3:0]        we_c;
    logic [31:0]       wdata_c;
    logic [31:0]       rdata_c;
    logic              req_err_c;
    logic [CE_W-1:0]   ce_c;

    assign req_err_c = is_misaligned(req_size, req_addr[1:0]) || (req_size == SZ_X) ||
                       (req_addr[31:BUS_ADDR_W] != '0);
    assign ce_c      = CE_W'(1) << req_addr[BUS_ADDR_W-1 -: CE_SEL_W];

    // Stores steer from the live request; loads extract using the latched request.
    mem_lane_align u_lane (
        .wr_size     (req_size),
        .wr_off      (req_addr[1:0]),
        .wdata       (req_wdata),
        .we_c        (we_c),
        .wdata_c     (wdata_c),
        .rd_size     (size_q),
        .rd_off      (off_q),
        .rd_unsigned (unsigned_q),
        .rdata       (bus_rdata),
        .rdata_c     (rdata_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            size_q     <= SZ_B;
            off_q      <= 2'b00;
            unsigned_q <= 1'b0;
            bus_ce     <= '0;
            bus_we     <= 4'b0000;
            bus_re     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        size_q     <= req_size;
                        off_q      <= req_addr[1:0];
                        unsigned_q <= req_unsigned;
                        if (req_err_c) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state    <= ACCESS;
                            bus_ce   <= ce_c;
                            bus_addr <= {req_addr[BUS_ADDR_W-1:2], 2'b00};
                            bus_re   <= !req_we;
                            if (req_we) begin
                                bus_we    <= we_c;
                                bus_wdata <= wdata_c;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (bus_re) begin
                        state <= RDWAIT;
                    end else begin
                        state     <= DONE;
                        bus_ce    <= '0;
                        bus_we    <= 4'b0000;
                        bus_addr  <= '0;
                        bus_wdata <= 32'h0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                    end
                end
                RDWAIT: begin
                    state     <= DONE;
                    bus_ce    <= '0;
                    bus_re    <= 1'b0;
                    bus_addr  <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= rdata_c;
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_BUS_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (state == DONE && rsp_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
